shift_left_twice_reg: RTL and testbench
=======================================

Name: shift_left_twice_reg

Overview:
- Registered shift-left-by-2 unit for the MIPS datapath.
- Converts a word offset (branch immediate / jump index) to a byte offset: out = in << 2, zero-filled.
- Sits between the sign-extend stage and the branch-target adder.
- Adds valid tracking and a lost-bits flag to the plain combinational shifter.

Parameters:
- width, 31, MSB index of data ports. Data buses are [width:0], so the default gives 32 bits. Legal range is width >= 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- shift_in  input  width+1  operand.
- in_valid  input  1  qualifies shift_in for capture this cycle.
- shift_out  output  width+1  registered result.
- out_valid  output  1  shift_out holds a result captured on the previous edge.
- lost_bits  output  1  registered flag: shift_in[width:width-1] was nonzero, so significant bits were discarded.
- sign_change  output  1  registered flag: shift_in[width] != shift_in[width-2], so the signed value wrapped.

Behaviour:
- Reset is synchronous and active-high. On a rising clk edge with reset=1:
  - shift_out = 0
  - out_valid = 0
  - lost_bits = 0
  - sign_change = 0
- Reset has priority over in_valid in the same cycle.
- Rising edge, reset=0, in_valid=1:
  - shift_out <= {shift_in[width-2:0], 2'b00}
  - lost_bits <= |shift_in[width:width-1]
  - sign_change <= shift_in[width] ^ shift_in[width-2]
  - out_valid <= 1
- Rising edge, reset=0, in_valid=0:
  - shift_out, lost_bits and sign_change hold their previous values.
  - out_valid <= 0.
- Latency is exactly 1 clock from capture edge to output.
- Throughput is one operand per cycle. There is no backpressure and no ready signal.
- The two LSBs of shift_out are always 0. The two MSBs of shift_in are discarded.
- Pure logical shift: no arithmetic saturation and no sign preservation beyond what the flags report.
- Reset asserted mid-stream clears all outputs on that edge. The first valid result after reset deasserts appears one cycle after the first in_valid=1 edge.
- No internal state other than the output registers. There are no X outputs after the first reset edge.

Optional Feature:
- Macro: SHIFT_LEFT_TWICE_COMB_EN.
- When defined, adds output port comb_out [width:0] = {shift_in[width-2:0], 2'b00}. This port is purely combinational, independent of clk, reset and in_valid, and is for same-cycle branch-target use.
- When undefined, the port does not exist and all logic is registered only.
- Registered port behaviour is identical in both builds.

Test Plan:
- Reset held 2 cycles, then in_valid=1, shift_in=0xAAAAAAAA -> next edge: shift_out=0xAAAAAAA8, lost_bits=1, sign_change=0, out_valid=1.
- shift_in=0xFFFFFFFF, in_valid=1 -> shift_out=0xFFFFFFFC, lost_bits=1, sign_change=0.
- shift_in=0x00000000, in_valid=1 -> shift_out=0x00000000, lost_bits=0, sign_change=0.
- shift_in=0x0000FFFF, in_valid=1 -> shift_out=0x0003FFFC, lost_bits=0. Then shift_in=0x20000000 -> shift_out=0x80000000, sign_change=1, lost_bits=0.
- in_valid=0 with shift_in changed to 0x12345678 -> shift_out holds its previous value, out_valid=0.
- reset=1 and in_valid=1 in the same cycle with shift_in=0xFFFFFFFF -> all outputs 0 on that edge.
- With SHIFT_LEFT_TWICE_COMB_EN defined, shift_in=0x0000FFFF -> comb_out=0x0003FFFC in the same cycle, before any clock edge.

Source files
------------

// File: rtl/shift_left_twice_reg.sv
// Registered shift-left-by-2 with valid tracking and discarded-bit / sign-wrap flags.
// Optional same-cycle comb_out port when SHIFT_LEFT_TWICE_COMB_EN is defined.
module shift_left_twice_reg #(
  parameter int width = 31
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [width:0] shift_in,
  input  logic           in_valid,
  output logic [width:0] shift_out,
  output logic           out_valid,
  output logic           lost_bits,
  output logic           sign_change
`ifdef SHIFT_LEFT_TWICE_COMB_EN
  ,
  output logic [width:0] comb_out
`endif
);

  function automatic logic [width:0] shl2(input logic [width:0] d);
    return {d[width-2:0], 2'b00};
  endfunction

  function automatic logic lost_fn(input logic [width:0] d);
    return |d[width:width-1];
  endfunction

  // Sign bit after the shift comes from d[width-2]; a mismatch means the signed value wrapped.
  function automatic logic sign_fn(input logic [width:0] d);
    return d[width] ^ d[width-2];
  endfunction

  logic [width:0] shifted_s;
  logic           lost_s;
  logic           sign_s;

  logic [width:0] shift_out_r;
  logic           out_valid_r;
  logic           lost_bits_r;
  logic           sign_change_r;

  // Next-value datapath shared by the registers and the optional combinational port.
  always_comb begin
    shifted_s = shl2(shift_in);
    lost_s    = lost_fn(shift_in);
    sign_s    = sign_fn(shift_in);
  end

  // Output registers: data and flags hold while idle, valid drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_out_r   <= '0;
      out_valid_r   <= 1'b0;
      lost_bits_r   <= 1'b0;
      sign_change_r <= 1'b0;
    end else if (in_valid) begin
      shift_out_r   <= shifted_s;
      out_valid_r   <= 1'b1;
      lost_bits_r   <= lost_s;
      sign_change_r <= sign_s;
    end else begin
      out_valid_r   <= 1'b0;
    end
  end

  assign shift_out   = shift_out_r;
  assign out_valid   = out_valid_r;
  assign lost_bits   = lost_bits_r;
  assign sign_change = sign_change_r;

`ifdef SHIFT_LEFT_TWICE_COMB_EN
  assign comb_out = shifted_s;
`endif

endmodule

// File: tb/tb_shift_left_twice_reg.sv
// Self-checking bench for shift_left_twice_reg: directed test-plan vectors pinned by
// literals, then randomized traffic checked every cycle against an arithmetic model.
module tb_shift_left_twice_reg;

  logic        clk;
  logic        reset;
  logic [31:0] shift_in;
  logic        in_valid;
  logic [31:0] shift_out;
  logic        out_valid;
  logic        lost_bits;
  logic        sign_change;
`ifdef SHIFT_LEFT_TWICE_COMB_EN
  logic [31:0] comb_out;
`endif

  int n_cmp = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  logic [31:0] m_out;
  logic        m_valid;
  logic        m_lost;
  logic        m_sign;

  shift_left_twice_reg #(.width(31)) dut (
    .clk         (clk),
    .reset       (reset),
    .shift_in    (shift_in),
    .in_valid    (in_valid),
    .shift_out   (shift_out),
    .out_valid   (out_valid),
    .lost_bits   (lost_bits),
    .sign_change (sign_change)
`ifdef SHIFT_LEFT_TWICE_COMB_EN
    ,
    .comb_out    (comb_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: multiply by four modulo 2^32, flags from value ranges.
  always @(posedge clk) begin
    if (reset) begin
      m_out   = 32'd0;
      m_valid = 1'b0;
      m_lost  = 1'b0;
      m_sign  = 1'b0;
    end else if (in_valid) begin
      m_out   = shift_in * 32'd4;
      m_valid = 1'b1;
      m_lost  = (shift_in >= 32'h4000_0000);
      m_sign  = (shift_in >= 32'h8000_0000) != (((shift_in / 32'h2000_0000) % 32'd2) == 32'd1);
    end else begin
      m_valid = 1'b0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("model_shift_out",   shift_out,          m_out);
      chk("model_out_valid",   {31'd0, out_valid},  {31'd0, m_valid});
      chk("model_lost_bits",   {31'd0, lost_bits},  {31'd0, m_lost});
      chk("model_sign_change", {31'd0, sign_change}, {31'd0, m_sign});
    end
  end

  task automatic step(input logic [31:0] d, input logic v, input logic r);
    shift_in = d;
    in_valid = v;
    reset    = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [31:0] e_out, input logic e_v,
                     input logic e_l, input logic e_s);
    chk({name, "_out"},  shift_out,            e_out);
    chk({name, "_vld"},  {31'd0, out_valid},   {31'd0, e_v});
    chk({name, "_lost"}, {31'd0, lost_bits},   {31'd0, e_l});
    chk({name, "_sign"}, {31'd0, sign_change}, {31'd0, e_s});
    chk({name, "_model"}, m_out,               e_out);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    shift_in = 32'd0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    lit("reset", 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    check_en = 1'b1;

`ifdef SHIFT_LEFT_TWICE_COMB_EN
    shift_in = 32'h0000_FFFF;
    #1;
    chk("comb_out", comb_out, 32'h0003_FFFC);
`endif

    step(32'hAAAA_AAAA, 1'b1, 1'b0); lit("aaaa",  32'hAAAA_AAA8, 1'b1, 1'b1, 1'b0);
    step(32'hFFFF_FFFF, 1'b1, 1'b0); lit("ffff",  32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0);
    step(32'h0000_0000, 1'b1, 1'b0); lit("zero",  32'h0000_0000, 1'b1, 1'b0, 1'b0);
    step(32'h0000_FFFF, 1'b1, 1'b0); lit("low16", 32'h0003_FFFC, 1'b1, 1'b0, 1'b0);
    step(32'h2000_0000, 1'b1, 1'b0); lit("wrap",  32'h8000_0000, 1'b1, 1'b0, 1'b1);
    step(32'h1234_5678, 1'b0, 1'b0); lit("hold",  32'h8000_0000, 1'b0, 1'b0, 1'b1);
    step(32'hFFFF_FFFF, 1'b1, 1'b1); lit("rstpri", 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    step(32'h4000_0001, 1'b1, 1'b0); lit("bit30", 32'h0000_0004, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] d;
      logic        v;
      logic        r;
      d = $urandom;
      case ($urandom_range(0, 3))
        0:       d = d & 32'h3FFF_FFFF;
        1:       d = d | 32'hC000_0000;
        default: d = d;
      endcase
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 31) == 0);
      step(d, v, r);
    end

    step(32'd0, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
